voq_cmd_queue_bank: RTL and testbench

VOQ_CMD_QUEUE_BANK -- requirements
Module: voq_cmd_queue_bank

---
 rtl/voq_pkg.sv | 12 +
 rtl/voq_sdp_ram.sv | 25 ++
 rtl/voq_cmd_queue_bank.sv | 147 ++++++++++++++
 tb/tb_voq_cmd_queue_bank.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/voq_pkg.sv
// Shared types for the VOQ command queue bank.
// Max-width queue index / occupancy types and parity width.
package voq_pkg;

  localparam int PAR_W  = 1;
  localparam int QIDX_W = 4;
  localparam int CNT_W  = 11;

  typedef logic [QIDX_W-1:0] qidx_t;
  typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/voq_sdp_ram.sv
// Simple dual-port storage shared by all queues.
// Address is {queue, pointer}; read data is registered, never reset.
module voq_sdp_ram #(
  parameter int WORDS = 2048,
  parameter int AW    = 11,
  parameter int EW    = 73
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [EW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [EW-1:0] rdata
);

  logic [EW-1:0] mem [WORDS];

  // Write port and registered read port; rdata holds between reads.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/voq_cmd_queue_bank.sv
// Bank of per-queue command FIFOs over one shared SDP RAM.
// Per-queue pointer/count logic, parity tag, sticky error flags.
module voq_cmd_queue_bank
  import voq_pkg::*;
#(
  parameter  int NUM_VOQ   = 4,
  parameter  int DEPTH     = 512,
  parameter  int WIDTH     = 72,
  parameter  int AFULL_LVL = DEPTH - 4,
  localparam int CW        = $clog2(NUM_VOQ),
  localparam int PW        = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      wr_en,
  input  logic [CW-1:0]             wr_ch,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      wr_inj_perr,
  input  logic                      rd_en,
  input  logic [CW-1:0]             rd_ch,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      rd_valid,
  output logic                      rd_perr,
  output logic [NUM_VOQ-1:0]        empty,
  output logic [NUM_VOQ-1:0]        full,
  output logic [NUM_VOQ-1:0]        afull,
  output logic [NUM_VOQ*(PW+1)-1:0] count,
  output logic                      wr_ovf,
  output logic                      rd_udf,
  input  logic                      err_clr
);

  localparam int AW = CW + PW;
  localparam int EW = WIDTH + PAR_W;

  logic                         wr_acc;
  logic                         rd_acc;
  logic                         ovf_ev;
  logic                         udf_ev;
  logic [NUM_VOQ-1:0]           wsel;
  logic [NUM_VOQ-1:0]           rsel;
  logic [NUM_VOQ-1:0][PW-1:0]   wptr_a;
  logic [NUM_VOQ-1:0][PW-1:0]   rptr_a;
  logic [EW-1:0]                wr_word;
  logic [EW-1:0]                ram_q;
  logic                         vld_q;
  logic                         seen_q;

  // Accept/reject decisions from registered flags; ignored in reset.
  always_comb begin
    wr_acc  = rstn & wr_en & ~full[wr_ch];
    rd_acc  = rstn & rd_en & ~empty[rd_ch];
    ovf_ev  = rstn & wr_en & full[wr_ch];
    udf_ev  = rstn & rd_en & empty[rd_ch];
    wr_word = {(^wr_data) ^ wr_inj_perr, wr_data};
    wsel    = '0;
    rsel    = '0;
    for (int i = 0; i < NUM_VOQ; i++) begin
      wsel[i] = wr_acc && (qidx_t'(wr_ch) == qidx_t'(i));
      rsel[i] = rd_acc && (qidx_t'(rd_ch) == qidx_t'(i));
    end
  end

  for (genvar gi = 0; gi < NUM_VOQ; gi++) begin : g_q
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [PW:0]   cnt;
    logic [PW:0]   cnt_n;
    logic          e_q;
    logic          f_q;
    logic          a_q;

    // Next occupancy: +1 write only, -1 read only, else hold.
    always_comb begin
      cnt_n = cnt;
      if (wsel[gi] && !rsel[gi]) cnt_n = cnt + 1'b1;
      else if (!wsel[gi] && rsel[gi]) cnt_n = cnt - 1'b1;
    end

    // Pointers wrap naturally; status flags registered from cnt_n.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
        e_q <= 1'b1;
        f_q <= 1'b0;
        a_q <= 1'b0;
      end else begin
        if (wsel[gi]) wp <= wp + 1'b1;
        if (rsel[gi]) rp <= rp + 1'b1;
        cnt <= cnt_n;
        e_q <= (cnt_t'(cnt_n) == '0);
        f_q <= (cnt_t'(cnt_n) == cnt_t'(DEPTH));
        a_q <= (cnt_t'(cnt_n) >= cnt_t'(AFULL_LVL));
      end
    end

    assign wptr_a[gi]                = wp;
    assign rptr_a[gi]                = rp;
    assign empty[gi]                 = e_q;
    assign full[gi]                  = f_q;
    assign afull[gi]                 = a_q;
    assign count[gi*(PW+1) +: PW+1]  = cnt;
  end

  voq_sdp_ram #(
    .WORDS (NUM_VOQ * DEPTH),
    .AW    (AW),
    .EW    (EW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr ({wr_ch, wptr_a[wr_ch]}),
    .wdata (wr_word),
    .re    (rd_acc),
    .raddr ({rd_ch, rptr_a[rd_ch]}),
    .rdata (ram_q)
  );

  // Read strobe and "RAM output is meaningful" marker for rd_data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q  <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      vld_q  <= rd_acc;
      seen_q <= seen_q | rd_acc;
    end
  end

  // Sticky errors; a new error in the clear cycle wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ovf <= 1'b0;
      rd_udf <= 1'b0;
    end else begin
      wr_ovf <= ovf_ev | (wr_ovf & ~err_clr);
      rd_udf <= udf_ev | (rd_udf & ~err_clr);
    end
  end

  assign rd_valid = vld_q;
  assign rd_data  = seen_q ? ram_q[WIDTH-1:0] : '0;
  assign rd_perr  = vld_q & ((^ram_q[WIDTH-1:0]) ^ ram_q[WIDTH]);

endmodule

// File: tb/tb_voq_cmd_queue_bank.sv
// Testbench for voq_cmd_queue_bank.
// Directed table, fill/drain, reset and random phase vs queue model.
module tb_voq_cmd_queue_bank;

  localparam int NV = 4;
  localparam int D  = 512;
  localparam int W  = 72;
  localparam int AF = D - 4;
  localparam int PW = 9;

  typedef logic [W:0] val_t;

  typedef struct {
    logic         we;
    logic [1:0]   wc;
    logic [W-1:0] wd;
    logic         inj;
    logic         re;
    logic [1:0]   rc;
    logic         clr;
    logic         x_vld;
    logic [W-1:0] x_data;
    logic         x_perr;
    logic         x_udf;
  } vec_t;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic                   wr_en;
  logic [1:0]             wr_ch;
  logic [W-1:0]           wr_data;
  logic                   wr_inj_perr;
  logic                   rd_en;
  logic [1:0]             rd_ch;
  logic [W-1:0]           rd_data;
  logic                   rd_valid;
  logic                   rd_perr;
  logic [NV-1:0]          empty;
  logic [NV-1:0]          full;
  logic [NV-1:0]          afull;
  logic [NV*(PW+1)-1:0]   count;
  logic                   wr_ovf;
  logic                   rd_udf;
  logic                   err_clr;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W:0]   mq [NV][$];
  logic         exp_valid;
  logic [W-1:0] exp_data;
  logic         exp_perr;
  logic         exp_ovf;
  logic         exp_udf;

  vec_t tbl [10];

  always #5 clk = ~clk;

  voq_cmd_queue_bank #(
    .NUM_VOQ   (NV),
    .DEPTH     (D),
    .WIDTH     (W),
    .AFULL_LVL (AF)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_data     (wr_data),
    .wr_inj_perr (wr_inj_perr),
    .rd_en       (rd_en),
    .rd_ch       (rd_ch),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_perr     (rd_perr),
    .empty       (empty),
    .full        (full),
    .afull       (afull),
    .count       (count),
    .wr_ovf      (wr_ovf),
    .rd_udf      (rd_udf),
    .err_clr     (err_clr)
  );

  task automatic chk(input string nm, input val_t act, input val_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  function automatic vec_t mk(
    input logic we, input logic [1:0] wc, input logic [W-1:0] wd,
    input logic inj, input logic re, input logic [1:0] rc,
    input logic clr, input logic xv, input logic [W-1:0] xd,
    input logic xp, input logic xu);
    vec_t v;
    v.we = we; v.wc = wc; v.wd = wd; v.inj = inj;
    v.re = re; v.rc = rc; v.clr = clr;
    v.x_vld = xv; v.x_data = xd; v.x_perr = xp; v.x_udf = xu;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) mq[i].delete();
    exp_valid = 1'b0;
    exp_data  = '0;
    exp_perr  = 1'b0;
    exp_ovf   = 1'b0;
    exp_udf   = 1'b0;
  endtask

  task automatic check_all();
    chk("rd_valid", val_t'(rd_valid), val_t'(exp_valid));
    chk("rd_data", val_t'(rd_data), val_t'(exp_data));
    chk("rd_perr", val_t'(rd_perr), val_t'(exp_perr));
    chk("wr_ovf", val_t'(wr_ovf), val_t'(exp_ovf));
    chk("rd_udf", val_t'(rd_udf), val_t'(exp_udf));
    for (int i = 0; i < NV; i++) begin
      int sz;
      sz = mq[i].size();
      chk($sformatf("count[%0d]", i),
          val_t'(count[i*(PW+1) +: PW+1]), val_t'(sz));
      chk($sformatf("empty[%0d]", i), val_t'(empty[i]), val_t'(sz == 0));
      chk($sformatf("full[%0d]", i), val_t'(full[i]), val_t'(sz == D));
      chk($sformatf("afull[%0d]", i), val_t'(afull[i]), val_t'(sz >= AF));
    end
  endtask

  // One clock: drive request, advance model, check after the edge.
  task automatic step(
    input logic we, input logic [1:0] wc, input logic [W-1:0] wd,
    input logic inj, input logic re, input logic [1:0] rc,
    input logic clr);
    logic [W:0] e;
    bit wfull;
    bit rempty;
    wfull  = (mq[wc].size() == D);
    rempty = (mq[rc].size() == 0);
    wr_en = we; wr_ch = wc; wr_data = wd; wr_inj_perr = inj;
    rd_en = re; rd_ch = rc; err_clr = clr;
    if (re && !rempty) begin
      e = mq[rc].pop_front();
      exp_valid = 1'b1;
      exp_data  = e[W-1:0];
      exp_perr  = e[W];
    end else begin
      exp_valid = 1'b0;
      exp_perr  = 1'b0;
    end
    if (we && !wfull) mq[wc].push_back({inj, wd});
    if (we && wfull) exp_ovf = 1'b1;
    else if (clr) exp_ovf = 1'b0;
    if (re && rempty) exp_udf = 1'b1;
    else if (clr) exp_udf = 1'b0;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 2'd0, '0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    wr_en = 1'b0; wr_ch = '0; wr_data = '0; wr_inj_perr = 1'b0;
    rd_en = 1'b0; rd_ch = '0; err_clr = 1'b0;
    model_reset();

    tbl[0] = mk(1'b1, 2'd2, 72'hA5, 1'b0, 1'b0, 2'd0, 1'b0,
                1'b0, 72'h0, 1'b0, 1'b0);
    tbl[1] = mk(1'b0, 2'd0, 72'h0, 1'b0, 1'b1, 2'd2, 1'b0,
                1'b1, 72'hA5, 1'b0, 1'b0);
    tbl[2] = mk(1'b0, 2'd0, 72'h0, 1'b0, 1'b1, 2'd1, 1'b0,
                1'b0, 72'hA5, 1'b0, 1'b1);
    tbl[3] = mk(1'b0, 2'd0, 72'h0, 1'b0, 1'b0, 2'd0, 1'b1,
                1'b0, 72'hA5, 1'b0, 1'b0);
    tbl[4] = mk(1'b1, 2'd0, 72'h3C, 1'b1, 1'b0, 2'd0, 1'b0,
                1'b0, 72'hA5, 1'b0, 1'b0);
    tbl[5] = mk(1'b0, 2'd0, 72'h0, 1'b0, 1'b1, 2'd0, 1'b0,
                1'b1, 72'h3C, 1'b1, 1'b0);
    tbl[6] = mk(1'b1, 2'd0, 72'h07, 1'b0, 1'b0, 2'd0, 1'b0,
                1'b0, 72'h3C, 1'b0, 1'b0);
    tbl[7] = mk(1'b0, 2'd0, 72'h0, 1'b0, 1'b1, 2'd0, 1'b0,
                1'b1, 72'h07, 1'b0, 1'b0);
    tbl[8] = mk(1'b0, 2'd0, 72'h0, 1'b0, 1'b1, 2'd0, 1'b1,
                1'b0, 72'h07, 1'b0, 1'b1);
    tbl[9] = mk(1'b0, 2'd0, 72'h0, 1'b0, 1'b0, 2'd0, 1'b1,
                1'b0, 72'h07, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check_all();
    rstn = 1'b1;

    for (int k = 0; k < 10; k++) begin
      step(tbl[k].we, tbl[k].wc, tbl[k].wd, tbl[k].inj,
           tbl[k].re, tbl[k].rc, tbl[k].clr);
      chk($sformatf("tbl%0d.valid", k), val_t'(rd_valid), val_t'(tbl[k].x_vld));
      chk($sformatf("tbl%0d.data", k), val_t'(rd_data), val_t'(tbl[k].x_data));
      chk($sformatf("tbl%0d.perr", k), val_t'(rd_perr), val_t'(tbl[k].x_perr));
      chk($sformatf("tbl%0d.udf", k), val_t'(rd_udf), val_t'(tbl[k].x_udf));
    end

    for (int k = 0; k < 5; k++)
      step(1'b1, 2'd3, rnd_word(), 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b1, 2'd3, rnd_word(), 1'b0, 1'b1, 2'd3, 1'b0);
    chk("same_q.count3", val_t'(count[3*(PW+1) +: PW+1]), val_t'(5));
    step(1'b1, 2'd1, rnd_word(), 1'b0, 1'b1, 2'd3, 1'b0);
    chk("diff_q.count1", val_t'(count[1*(PW+1) +: PW+1]), val_t'(1));
    chk("diff_q.count3", val_t'(count[3*(PW+1) +: PW+1]), val_t'(4));

    for (int k = 0; k < D; k++) begin
      step(1'b1, 2'd0, W'(k), 1'b0, 1'b0, 2'd0, 1'b0);
      if (k == AF - 2) chk("afull_below", val_t'(afull[0]), val_t'(0));
      if (k == AF - 1) chk("afull_at", val_t'(afull[0]), val_t'(1));
    end
    chk("fill.full0", val_t'(full[0]), val_t'(1));
    step(1'b1, 2'd0, 72'hDEAD, 1'b0, 1'b0, 2'd0, 1'b1);
    chk("ovf.set", val_t'(wr_ovf), val_t'(1));
    chk("ovf.count0", val_t'(count[PW:0]), val_t'(D));
    for (int k = 0; k < D; k++) begin
      step(1'b0, 2'd0, '0, 1'b0, 1'b1, 2'd0, 1'b0);
      chk("drain.data", val_t'(rd_data), val_t'(k));
    end
    step(1'b0, 2'd0, '0, 1'b0, 1'b0, 2'd0, 1'b1);

    for (int k = 0; k < 2000; k++) begin
      step(1'($urandom_range(0, 99) < 60), 2'($urandom_range(0, 3)),
           rnd_word(), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 99) < 45), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 19) == 0));
    end

    step(1'b1, 2'd1, 72'h55, 1'b0, 1'b0, 2'd0, 1'b1);
    step(1'b0, 2'd0, '0, 1'b0, 1'b1, 2'd1, 1'b0);
    chk("pre_rst.valid", val_t'(rd_valid), val_t'(1));
    rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    wr_en = 1'b1; wr_ch = 2'd2; rd_en = 1'b1; rd_ch = 2'd1;
    repeat (2) begin
      @(posedge clk);
      #1;
      check_all();
    end
    rstn = 1'b1;
    idle();
    chk("post_rst.valid", val_t'(rd_valid), val_t'(0));
    chk("post_rst.empty", val_t'(empty), val_t'(4'hF));
    step(1'b1, 2'd2, 72'h77, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("post_rst.count2", val_t'(count[2*(PW+1) +: PW+1]), val_t'(1));
    step(1'b0, 2'd0, '0, 1'b0, 1'b1, 2'd2, 1'b0);
    chk("post_rst.data", val_t'(rd_data), val_t'(72'h77));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
